// File: rtl/sp_uram_pipe.sv
// sp_uram_pipe: banked, byte-writable single-port UltraRAM wrapper with a
// configurable read pipeline and a valid-tagged output.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset (pipeline only, not memory)
//   en         - access request, one per cycle, no backpressure
//   wr_en      - qualifies en as a write
//   byte_en    - per-lane write enable (ignored on reads)
//   addr       - word address; top log2(NUM_BANKS) bits select the bank
//   din        - write data
//   dout       - read data, held between valid results
//   dout_valid - one-cycle pulse, READ_LATENCY cycles after a tagged access
module sp_uram_pipe #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned NUM_BANKS    = 4,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned WRITE_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int unsigned SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int unsigned ROW_W     = ADDR_WIDTH - BANK_BITS;
  localparam int unsigned DEPTH     = 1 << ROW_W;

  // Elaboration-time parameter checks
  if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
    $error("sp_uram_pipe: READ_LATENCY must be in 1..8");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 16 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("sp_uram_pipe: NUM_BANKS must be a power of 2 in 1..16");
  end
  if (BYTE_WIDTH == 0 || (DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("sp_uram_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (WRITE_MODE > 2) begin : g_bad_mode
    $error("sp_uram_pipe: WRITE_MODE must be 0, 1 or 2");
  end
  if (BANK_BITS >= ADDR_WIDTH) begin : g_bad_addr
    $error("sp_uram_pipe: ADDR_WIDTH too small for NUM_BANKS");
  end

  // Address split
  logic [SEL_W-1:0] bank_sel;
  logic [ROW_W-1:0] row;

  if (BANK_BITS > 0) begin : g_sel
    assign bank_sel = addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign row      = addr[ROW_W-1:0];
  end else begin : g_nosel
    assign bank_sel = '0;
    assign row      = addr;
  end

  // NO_CHANGE writes produce no result, so they carry no tag
  logic tag_in;
  assign tag_in = en && (!wr_en || (WRITE_MODE != 2));

  // Banks with registered read (stage 1)
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  bank_en;
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;

    assign bank_en = en && (bank_sel == SEL_W'(b));

    always_ff @(posedge clk) begin
      if (rst_n && bank_en && wr_en) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (byte_en[i]) begin
            mem[row][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end

    // Read-during-write: old word, merged word, or hold for NO_CHANGE
    always_comb begin
      rd_d = rd_q;
      if (bank_en) begin
        rd_d = mem[row];
        if (wr_en) begin
          if (WRITE_MODE == 1) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              if (byte_en[i]) begin
                rd_d[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
              end
            end
          end else if (WRITE_MODE == 2) begin
            rd_d = rd_q;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign bank_rd[b] = rd_q;
  end

  // Valid tag pipeline
  logic [READ_LATENCY:1] vld_d;
  logic [READ_LATENCY:1] vld_q;

  always_comb begin
    vld_d[1] = tag_in;
    for (int unsigned k = 2; k <= READ_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Bank select travels with the tag; it only moves on tagged accesses so the
  // mux keeps pointing at the last result, which gives output hold at latency 1
  logic [DATA_WIDTH-1:0] mux_out;

  if (NUM_BANKS > 1) begin : g_mux
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] sel_q;

    always_comb begin
      sel_d = tag_in ? bank_sel : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sel_q <= '0;
      end else begin
        sel_q <= sel_d;
      end
    end

    assign mux_out = bank_rd[sel_q];
  end else begin : g_nomux
    assign mux_out = bank_rd[0];
  end

  // Stages 2..READ_LATENCY load only when their incoming tag is set
  if (READ_LATENCY == 1) begin : g_lat1
    assign dout = mux_out;
  end else begin : g_latn
    logic [DATA_WIDTH-1:0] pdata_d [2:READ_LATENCY];
    logic [DATA_WIDTH-1:0] pdata_q [2:READ_LATENCY];

    always_comb begin
      pdata_d[2] = vld_q[1] ? mux_out : pdata_q[2];
      for (int unsigned k = 3; k <= READ_LATENCY; k++) begin
        pdata_d[k] = vld_q[k-1] ? pdata_q[k-1] : pdata_q[k];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 2; k <= READ_LATENCY; k++) begin
          pdata_q[k] <= '0;
        end
      end else begin
        for (int unsigned k = 2; k <= READ_LATENCY; k++) begin
          pdata_q[k] <= pdata_d[k];
        end
      end
    end

    assign dout = pdata_q[READ_LATENCY];
  end

  assign dout_valid = vld_q[READ_LATENCY];

endmodule

// File: doc/sp_uram_pipe.md
Name: sp_uram_pipe

Overview:
- Next-generation single-port UltraRAM wrapper: banked, byte-writable, with a configurable output pipeline.
- Adds a selectable read-during-write mode and a valid-tagged output, so deep pipelined datapaths can track returned data without their own delay counters.
- Sits between datapath engines and on-chip URAM storage; accepts one access per cycle, fully pipelined.

Parameters:
- DATA_WIDTH, 64, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 16, total word address width across all banks.
- NUM_BANKS, 4, number of URAM banks; power of 2, 1..16; bank = addr[ADDR_WIDTH-1 -: log2(NUM_BANKS)].
- BYTE_WIDTH, 8, bits per write-enable lane.
- READ_LATENCY, 3, cycles from accepted access to dout_valid; legal range 1..8.
- WRITE_MODE, 0, port behaviour on write cycles: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, access request; one access per cycle when high.
- wr_en, input, 1, qualifies en as a write.
- byte_en, input, DATA_WIDTH/BYTE_WIDTH, per-lane write enable; ignored on reads.
- addr, input, ADDR_WIDTH, word address.
- din, input, DATA_WIDTH, write data.
- dout, output, DATA_WIDTH, read data.
- dout_valid, output, 1, single-cycle pulse marking dout as the result of an access.

Behaviour:
- Reset: asynchronous, active-low, on rst_n. While rst_n=0: dout=0, dout_valid=0, all pipeline valid bits 0, pipeline data registers 0. Memory contents are not reset.
- Acceptance: no backpressure. Every cycle with en=1 is an access; en=0 is idle. wr_en, byte_en, addr and din are ignored when en=0.
- Banking:
  - Bank select = top log2(NUM_BANKS) address bits; the row index within the bank is the remaining low bits.
  - Only the selected bank is enabled (per-bank enable for power).
  - NUM_BANKS=1 means no select bits.
- Write: on an accepted write, each lane i with byte_en[i]=1 gets din lane i at addr. Lanes with byte_en[i]=0 are untouched. byte_en all-zero is a legal no-op write.
- Read data path:
  - Stage 1: registered read of the selected bank, storage marked ultra RAM style.
  - The bank select is carried alongside and used for a registered mux in stage 2.
  - Further registers follow to reach READ_LATENCY total. READ_LATENCY=1 collapses the mux into the stage-1 output path, combinational mux after the bank registers.
- Valid tracking:
  - A 1-bit tag enters the pipeline when en=1 and (wr_en=0 or WRITE_MODE!=2).
  - dout_valid is that tag delayed exactly READ_LATENCY cycles.
- Output hold: dout updates only when a valid tag reaches the output; otherwise it holds its last value.
- Data returned on a write cycle:
  - READ_FIRST: old word before the write.
  - WRITE_FIRST: merged word, i.e. din on enabled lanes and old data on the others.
  - NO_CHANGE: no dout_valid pulse, dout unchanged.
- Back-to-back: a read of an address in the cycle after a write to it returns the new data, in every mode.
- Throughput: full rate. N consecutive accesses produce N consecutive dout_valid pulses in order, accesses to different banks included.
- Reset mid-operation: all in-flight results are dropped (no dout_valid after reset release for pre-reset accesses). A write accepted on an edge before rst_n falls is committed.
- Illegal parameters (READ_LATENCY out of range, NUM_BANKS not a power of 2, DATA_WIDTH % BYTE_WIDTH != 0) stop elaboration via a generate-time error.
- Uninitialised locations read X in simulation; benches write before reading.

Test Plan:
- Write 0x1122334455667788 to addr 0x0010 (byte_en=0xFF), then read 0x0010 -> dout_valid exactly 3 cycles after the read, dout=0x1122334455667788.
- Partial write byte_en=0x0F, din=0xAAAAAAAABBBBBBBB to addr 0x0010, then read -> 0x11223344BBBBBBBB.
- Write on a preloaded word 0x5 at addr 0x4000 (bank 1) with din=0x9, full byte_en, per mode:
  - WRITE_MODE=0: dout=0x5 with dout_valid.
  - WRITE_MODE=1: dout=0x9 with dout_valid.
  - WRITE_MODE=2: no dout_valid and dout unchanged.
- Streaming reads of addr 0x0000, 0x4000, 0x8000, 0xC000 (one per bank, preloaded 1, 2, 3, 4) on 4 consecutive cycles -> 4 consecutive dout_valid pulses with data 1, 2, 3, 4; then idle -> dout holds 4 and dout_valid=0.
- Reset: issue 3 reads, assert rst_n=0 one cycle later for 2 cycles -> dout=0 and dout_valid=0 immediately on rst_n low, and no dout_valid after release; previously written memory data is still readable afterwards.
- Latency sweep READ_LATENCY=1 and 8 with NUM_BANKS=1 and 16: a read issued at cycle t gives dout_valid at exactly t+READ_LATENCY with correct data.
